operand_fetch: RTL and testbench

OPERAND_FETCH -- requirements
Module: operand_fetch

---
 rtl/operand_fetch_pkg.sv | 17 +
 rtl/operand_fwd_mux.sv | 55 +++++
 rtl/operand_fetch.sv | 126 ++++++++++++
 tb/tb_operand_fetch.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/operand_fetch_pkg.sv
// Shared widths and constants for the operand fetch stage.
// Helper for the saturating bubble counter.
package operand_fetch_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int OP_W   = 8;
    localparam int CNT_W  = 16;

    localparam logic [DATA_W-1:0] ZERO_W = '0;
    localparam logic [CNT_W-1:0]  CNT_MAX = '1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/operand_fwd_mux.sv
// Resolves one source operand: zero reg, EX/MEM bypass, regfile.
// Bypass paths exist only with OPERAND_FETCH_FWD_EN defined.
module operand_fwd_mux
    import operand_fetch_pkg::*;
#(
    parameter int DW = DATA_W,
    parameter int AW = ADDR_W
) (
    input  logic          use_src,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] rdata,
    input  logic          ex_we,
    input  logic [AW-1:0] ex_waddr,
    input  logic [DW-1:0] ex_wdata,
    input  logic          ex_is_load,
    input  logic          mem_we,
    input  logic [AW-1:0] mem_waddr,
    input  logic [DW-1:0] mem_wdata,
    output logic [DW-1:0] data
);

`ifdef OPERAND_FETCH_FWD_EN
    logic ex_hit;
    logic mem_hit;

    assign ex_hit  = ex_we && (ex_waddr == addr) && !ex_is_load;
    assign mem_hit = mem_we && (mem_waddr == addr);

    // Priority: r0/unused, youngest producer (EX), then MEM, then regfile.
    always_comb begin
        data = DW'(ZERO_W);
        if (!use_src || addr == '0)
            data = DW'(ZERO_W);
        else if (ex_hit)
            data = ex_wdata;
        else if (mem_hit)
            data = mem_wdata;
        else
            data = rdata;
    end
`else
    logic unused_fwd;

    assign unused_fwd = ^{ex_we, ex_waddr, ex_wdata, ex_is_load,
                          mem_we, mem_waddr, mem_wdata};

    // No bypass: any in-flight producer stalls upstream instead.
    always_comb begin
        data = DW'(ZERO_W);
        if (use_src && addr != '0)
            data = rdata;
    end
`endif

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage: regfile read, hazard stall, EX pipeline register.
// OPERAND_FETCH_FWD_EN enables EX/MEM bypass; otherwise matches stall.
module operand_fetch
    import operand_fetch_pkg::*;
#(
    parameter int DATA_W = operand_fetch_pkg::DATA_W,
    parameter int ADDR_W = operand_fetch_pkg::ADDR_W,
    parameter int OP_W   = operand_fetch_pkg::OP_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_rs1,
    input  logic [ADDR_W-1:0] in_rs2,
    input  logic              in_rs1_use,
    input  logic              in_rs2_use,
    input  logic [DATA_W-1:0] in_imm,
    input  logic              in_imm_sel,
    input  logic [ADDR_W-1:0] in_rd,
    input  logic              in_rd_we,
    input  logic [OP_W-1:0]   in_aluop,
    output logic              re1,
    output logic [ADDR_W-1:0] raddr1,
    output logic              re2,
    output logic [ADDR_W-1:0] raddr2,
    input  logic [DATA_W-1:0] rdata1,
    input  logic [DATA_W-1:0] rdata2,
    input  logic              ex_we,
    input  logic [ADDR_W-1:0] ex_waddr,
    input  logic [DATA_W-1:0] ex_wdata,
    input  logic              ex_is_load,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_waddr,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_op1,
    output logic [DATA_W-1:0] out_op2,
    output logic [ADDR_W-1:0] out_rd,
    output logic              out_rd_we,
    output logic [OP_W-1:0]   out_aluop,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic [DATA_W-1:0] src1;
    logic [DATA_W-1:0] src2;
    logic ex_m1, ex_m2;
    logic hazard;
    logic accept;
    logic load;

    assign re1    = in_valid & in_rs1_use;
    assign re2    = in_valid & in_rs2_use;
    assign raddr1 = in_rs1;
    assign raddr2 = in_rs2;

    operand_fwd_mux #(.DW(DATA_W), .AW(ADDR_W)) u_mux1 (
        .use_src(in_rs1_use), .addr(in_rs1), .rdata(rdata1),
        .ex_we(ex_we), .ex_waddr(ex_waddr), .ex_wdata(ex_wdata),
        .ex_is_load(ex_is_load), .mem_we(mem_we),
        .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .data(src1)
    );

    operand_fwd_mux #(.DW(DATA_W), .AW(ADDR_W)) u_mux2 (
        .use_src(in_rs2_use), .addr(in_rs2), .rdata(rdata2),
        .ex_we(ex_we), .ex_waddr(ex_waddr), .ex_wdata(ex_wdata),
        .ex_is_load(ex_is_load), .mem_we(mem_we),
        .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .data(src2)
    );

    assign ex_m1 = in_rs1_use && ex_we && ex_waddr == in_rs1 && ex_waddr != '0;
    assign ex_m2 = in_rs2_use && ex_we && ex_waddr == in_rs2 && ex_waddr != '0;

`ifdef OPERAND_FETCH_FWD_EN
    logic unused_mem;
    assign unused_mem = ^{mem_we, mem_waddr};
    assign hazard = in_valid && ex_is_load && (ex_m1 || ex_m2);
`else
    logic mem_m1, mem_m2;
    logic unused_ld;
    assign unused_ld = ex_is_load;
    assign mem_m1 = in_rs1_use && mem_we && mem_waddr == in_rs1 && mem_waddr != '0;
    assign mem_m2 = in_rs2_use && mem_we && mem_waddr == in_rs2 && mem_waddr != '0;
    assign hazard = in_valid && (ex_m1 || ex_m2 || mem_m1 || mem_m2);
`endif

    assign accept   = ~out_valid | out_ready;
    assign in_ready = accept & ~hazard & ~flush & ~rst;
    assign load     = in_valid & in_ready;

    // Output register: flush kills, accept captures or bubbles, else hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_op1   <= DATA_W'(ZERO_W);
            out_op2   <= DATA_W'(ZERO_W);
            out_rd    <= '0;
            out_rd_we <= 1'b0;
            out_aluop <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
            out_rd_we <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_op1   <= src1;
            out_op2   <= in_imm_sel ? in_imm : src2;
            out_rd    <= in_rd;
            out_rd_we <= in_rd_we;
            out_aluop <= in_aluop;
        end else if (accept) begin
            out_valid <= 1'b0;
            out_rd_we <= 1'b0;
        end
    end

    // Count edges where a hazard bubble goes downstream.
    always_ff @(posedge clk) begin
        if (rst)
            stall_cnt <= '0;
        else if (accept && hazard && !flush)
            stall_cnt <= sat_inc(stall_cnt);
    end

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch, both forwarding builds.
// Expected values are hand computed per scenario.
module tb_operand_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [4:0]  in_rs1, in_rs2;
    logic        in_rs1_use, in_rs2_use;
    logic [31:0] in_imm;
    logic        in_imm_sel;
    logic [4:0]  in_rd;
    logic        in_rd_we;
    logic [7:0]  in_aluop;
    logic        re1, re2;
    logic [4:0]  raddr1, raddr2;
    logic [31:0] rdata1, rdata2;
    logic        ex_we;
    logic [4:0]  ex_waddr;
    logic [31:0] ex_wdata;
    logic        ex_is_load;
    logic        mem_we;
    logic [4:0]  mem_waddr;
    logic [31:0] mem_wdata;
    logic        flush;
    logic        out_valid, out_ready;
    logic [31:0] out_op1, out_op2;
    logic [4:0]  out_rd;
    logic        out_rd_we;
    logic [7:0]  out_aluop;
    logic [15:0] stall_cnt;

    int checks = 0;
    int errors = 0;
    int exp_stall = 0;
    logic [31:0] held1, held2;

    always #5 clk = ~clk;

    operand_fetch dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_rs1_use(in_rs1_use), .in_rs2_use(in_rs2_use),
        .in_imm(in_imm), .in_imm_sel(in_imm_sel),
        .in_rd(in_rd), .in_rd_we(in_rd_we), .in_aluop(in_aluop),
        .re1(re1), .raddr1(raddr1), .re2(re2), .raddr2(raddr2),
        .rdata1(rdata1), .rdata2(rdata2),
        .ex_we(ex_we), .ex_waddr(ex_waddr), .ex_wdata(ex_wdata),
        .ex_is_load(ex_is_load),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_op1(out_op1), .out_op2(out_op2),
        .out_rd(out_rd), .out_rd_we(out_rd_we), .out_aluop(out_aluop),
        .stall_cnt(stall_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_wb();
        ex_we = 0; ex_waddr = 0; ex_wdata = 0; ex_is_load = 0;
        mem_we = 0; mem_waddr = 0; mem_wdata = 0;
    endtask

    task automatic issue(input logic [4:0] rs1, input logic u1,
                         input logic [4:0] rs2, input logic u2,
                         input logic [31:0] imm, input logic isel,
                         input logic [4:0] rd, input logic [7:0] op);
        in_valid = 1; in_rs1 = rs1; in_rs1_use = u1;
        in_rs2 = rs2; in_rs2_use = u2; in_imm = imm;
        in_imm_sel = isel; in_rd = rd; in_rd_we = 1; in_aluop = op;
    endtask

    initial begin
        rst = 1; in_valid = 0; in_rs1 = 0; in_rs2 = 0;
        in_rs1_use = 0; in_rs2_use = 0; in_imm = 0; in_imm_sel = 0;
        in_rd = 0; in_rd_we = 0; in_aluop = 0;
        rdata1 = 0; rdata2 = 0; flush = 0; out_ready = 1;
        clr_wb();
        step();
        step();
        in_valid = 1; #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_valid", out_valid, 0);
        check("rst_op1", out_op1, 0);
        check("rst_stall", stall_cnt, 0);
        in_valid = 0; rst = 0;
        step();

        // EX forward of r3 over regfile value
        issue(3, 1, 0, 0, 0, 0, 1, 8'h10);
        rdata1 = 32'h11;
        ex_we = 1; ex_waddr = 3; ex_wdata = 32'h22; #1;
`ifdef OPERAND_FETCH_FWD_EN
        check("fwd_ex_ready", in_ready, 1);
        step();
        check("fwd_ex_valid", out_valid, 1);
        check("fwd_ex_op1", out_op1, 32'h22);
`else
        check("ex_haz_ready", in_ready, 0);
        step();
        exp_stall++;
        check("ex_haz_bubble", out_valid, 0);
        check("ex_haz_cnt", stall_cnt, exp_stall);
        clr_wb(); #1;
        check("ex_haz_release", in_ready, 1);
        step();
        check("rf_op1", out_op1, 32'h11);
`endif

        // EX and MEM both write r3
        ex_we = 1; ex_waddr = 3; ex_wdata = 32'h22;
        mem_we = 1; mem_waddr = 3; mem_wdata = 32'h33; #1;
`ifdef OPERAND_FETCH_FWD_EN
        step();
        check("ex_prio_op1", out_op1, 32'h22);
`else
        ex_we = 0; #1;
        check("mem_haz_ready", in_ready, 0);
        step();
        exp_stall++;
        check("mem_haz_cnt", stall_cnt, exp_stall);
        clr_wb(); step();
        check("mem_rel_op1", out_op1, 32'h11);
`endif
        clr_wb();

        // r0 source with EX writing r0, immediate op2
        issue(0, 1, 5, 1, 32'h1234, 1, 7, 8'hA5);
        rdata1 = 32'h77; rdata2 = 32'h99;
        ex_we = 1; ex_waddr = 0; ex_wdata = 32'h55; #1;
        check("r0_ready", in_ready, 1);
        check("re2", re2, 1);
        check("raddr2", raddr2, 5);
        step();
        check("r0_op1", out_op1, 0);
        check("imm_op2", out_op2, 32'h1234);
        check("pass_rd", out_rd, 7);
        check("pass_we", out_rd_we, 1);
        check("pass_op", out_aluop, 8'hA5);
        clr_wb();

        // Unused rs1 reads zero; rs2 from regfile
        issue(6, 0, 5, 1, 32'h1234, 0, 8, 8'h3C); #1;
        check("re1_off", re1, 0);
        step();
        check("unused_op1", out_op1, 0);
        check("rf_op2", out_op2, 32'h99);
        check("b2b_valid", out_valid, 1);

        // Load-use on rs2
        issue(1, 1, 4, 1, 0, 0, 9, 8'h01);
        rdata1 = 32'h0A; rdata2 = 32'h44;
        ex_we = 1; ex_waddr = 4; ex_wdata = 32'hDEAD; ex_is_load = 1; #1;
        check("lu_ready", in_ready, 0);
        step();
        exp_stall++;
        check("lu_bubble", out_valid, 0);
        check("lu_rd_we", out_rd_we, 0);
        check("lu_cnt", stall_cnt, exp_stall);
        clr_wb(); #1;
        check("lu_release", in_ready, 1);
        step();
        check("lu_valid", out_valid, 1);
        check("lu_op2", out_op2, 32'h44);

        // Backpressure holds outputs, then flush
        out_ready = 0;
        issue(2, 1, 2, 1, 0, 0, 10, 8'h77);
        rdata1 = 32'hAAAA; rdata2 = 32'hBBBB; #1;
        check("bp_ready", in_ready, 0);
        held1 = out_op1; held2 = out_op2;
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp_valid", out_valid, 1);
            check("bp_op1", out_op1, 32'h0A);
            check("bp_op2", out_op2, 32'h44);
            check("bp_rd", out_rd, 9);
        end
        flush = 1; #1;
        check("fl_ready", in_ready, 0);
        step();
        check("fl_valid", out_valid, 0);
        check("fl_hold_op1", out_op1, held1);
        flush = 0; out_ready = 1;

        // Stall until counter reaches 5, then reset mid-stall
        issue(4, 1, 0, 0, 0, 0, 11, 8'h02);
        ex_we = 1; ex_waddr = 4; ex_is_load = 1; #1;
        while (exp_stall < 5) begin
            step();
            exp_stall++;
        end
        check("cnt5", stall_cnt, 5);
        rst = 1; step();
        check("mr_valid", out_valid, 0);
        check("mr_op1", out_op1, 0);
        check("mr_op2", out_op2, 0);
        check("mr_rd", out_rd, 0);
        check("mr_aluop", out_aluop, 0);
        check("mr_cnt", stall_cnt, 0);
        check("mr_ready", in_ready, 0);
        rst = 0; clr_wb(); #1;
        check("post_rst_ready", in_ready, 1);
        step();
        check("post_rst_cnt", stall_cnt, 0);
        check("post_rst_valid", out_valid, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
